// File: rtl/baccarat_pkg.sv
// baccarat_pkg: dealer FSM states, card encoding and the baccarat draw rules
package baccarat_pkg;

    typedef enum logic [3:0] {
        ST_P1, ST_D1, ST_P2, ST_D2, ST_EVAL1, ST_P3, ST_EVAL2, ST_D3, ST_SCORE, ST_DONE
    } state_t;

    localparam logic [3:0] CARD_NONE = 4'd0;
    localparam logic [3:0] CARD_ACE  = 4'd1;
    localparam logic [3:0] CARD_KING = 4'd13;

    // Tens and faces count as zero points; an empty slot is also zero.
    function automatic logic [3:0] card_point(input logic [3:0] card);
        return (card >= 4'd10) ? 4'd0 : card;
    endfunction

    // Banker third-card tableau, keyed on the banker total and the player's third-card points.
    function automatic logic dealer_draws(input logic [3:0] dscore, input logic [3:0] p3_point);
        return (dscore <= 4'd2) ||
               (dscore == 4'd3 && p3_point != 4'd8) ||
               (dscore == 4'd4 && p3_point >= 4'd2 && p3_point <= 4'd7) ||
               (dscore == 4'd5 && p3_point >= 4'd4 && p3_point <= 4'd7) ||
               (dscore == 4'd6 && p3_point >= 4'd6 && p3_point <= 4'd7);
    endfunction

endpackage

// File: rtl/card_dealer_if.sv
// card_dealer_if: card registers written by the dealer and hand totals returned by scoring
interface card_dealer_if;
    logic [3:0] pcard1, pcard2, pcard3;
    logic [3:0] dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore;

    modport master (output pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, input pscore, dscore);
    modport slave  (input pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, output pscore, dscore);
endinterface

// File: rtl/card_dealer_card_source.sv
// card_source: free-running 1..13 card counter, independent of step
module card_source
    import baccarat_pkg::*;
(
    input  logic       slow_clock,
    input  logic       resetb,
    output logic [3:0] card
);

    // Advance every edge, wrapping King back to Ace.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) card <= CARD_ACE;
        else         card <= (card == CARD_KING) ? CARD_ACE : card + 4'd1;
    end

endmodule

// File: rtl/card_dealer.sv
// card_dealer: baccarat deal-order FSM driving the six card registers and the win flags
module card_dealer
    import baccarat_pkg::*;
(
    input  logic          slow_clock,
    input  logic          resetb,
    input  logic          step,
    card_dealer_if.master bus,
    output logic          player_win,
    output logic          dealer_win,
    output logic          done
);

    state_t     state;
    logic [3:0] card;

    card_source u_src (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .card       (card)
    );

    // One deal step per step pulse; scores are only read in EVAL1/EVAL2/SCORE.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state      <= ST_P1;
            bus.pcard1 <= CARD_NONE;
            bus.pcard2 <= CARD_NONE;
            bus.pcard3 <= CARD_NONE;
            bus.dcard1 <= CARD_NONE;
            bus.dcard2 <= CARD_NONE;
            bus.dcard3 <= CARD_NONE;
            player_win <= 1'b0;
            dealer_win <= 1'b0;
            done       <= 1'b0;
        end else if (step) begin
            case (state)
                ST_P1: begin
                    bus.pcard1 <= card;
                    state      <= ST_D1;
                end
                ST_D1: begin
                    bus.dcard1 <= card;
                    state      <= ST_P2;
                end
                ST_P2: begin
                    bus.pcard2 <= card;
                    state      <= ST_D2;
                end
                ST_D2: begin
                    bus.dcard2 <= card;
                    state      <= ST_EVAL1;
                end
                ST_EVAL1: state <= (bus.pscore >= 4'd8 || bus.dscore >= 4'd8) ? ST_SCORE :
                                   (bus.pscore <= 4'd5)                      ? ST_P3    :
                                   (bus.dscore <= 4'd5)                      ? ST_D3    : ST_SCORE;
                ST_P3: begin
                    bus.pcard3 <= card;
                    state      <= ST_EVAL2;
                end
                ST_EVAL2: state <= dealer_draws(bus.dscore, card_point(bus.pcard3)) ? ST_D3 : ST_SCORE;
                ST_D3: begin
                    bus.dcard3 <= card;
                    state      <= ST_SCORE;
                end
                ST_SCORE: begin
                    player_win <= bus.pscore >= bus.dscore;
                    dealer_win <= bus.dscore >= bus.pscore;
                    done       <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    bus.pcard1 <= CARD_NONE;
                    bus.pcard2 <= CARD_NONE;
                    bus.pcard3 <= CARD_NONE;
                    bus.dcard1 <= CARD_NONE;
                    bus.dcard2 <= CARD_NONE;
                    bus.dcard3 <= CARD_NONE;
                    player_win <= 1'b0;
                    dealer_win <= 1'b0;
                    done       <= 1'b0;
                    state      <= ST_P1;
                end
                default: state <= ST_P1;
            endcase
        end
    end

endmodule
